serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 136 +++++++++++++
 tb/tb_serial_adder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: operands load in parallel, one full-adder bit per
// clock LSB-first, and the W-bit sum plus carry-out return in parallel.

module hf_gate (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b
);

  assign sum  = a ^ b;
  assign cout = a & b;

endmodule

module serial_adder #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum_out,
  output logic         cout
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  sa_q, sa_d;
  logic [W-1:0]  sb_q, sb_d;
  logic [W-1:0]  sr_q, sr_d;
  logic          c_q, c_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;

  // Full-adder bit cell: two half adders with their carries ORed.
  logic p_bit, g_lo, g_hi, s_bit, c_next;

  hf_gate u_ha_ab (
    .sum  (p_bit),
    .cout (g_lo),
    .a    (sa_q[0]),
    .b    (sb_q[0])
  );

  hf_gate u_ha_pc (
    .sum  (s_bit),
    .cout (g_hi),
    .a    (p_bit),
    .b    (c_q)
  );

  assign c_next = g_lo | g_hi;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first so no path
    // through the case statement leaves one unassigned (no latch inferred).
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    c_d     = c_q;
    count_d = count_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          c_d     = 1'b0;
          count_d = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SHIFT: begin
        c_d     = c_next;
        sr_d    = {s_bit, sr_q[W-1:1]};
        sa_d    = {1'b0, sa_q[W-1:1]};
        sb_d    = {1'b0, sb_q[W-1:1]};
        count_d = count_q + CW'(1);
        if (count_q == LAST_BIT) begin
          sum_d   = {s_bit, sr_q[W-1:1]};
          cout_d  = c_next;
          state_d = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, matching real hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      c_q     <= 1'b0;
      count_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      c_q     <= c_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy    = (state_q == ST_SHIFT);
  assign done    = (state_q == ST_DONE);
  assign sum_out = sum_q;
  assign cout    = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: expected {cout,sum} values are queued
// when an operation is launched and compared whenever done pulses.

module tb_serial_adder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done;
  logic [W-1:0] sum_out;
  logic         cout;

  int n_checks = 0;
  int n_errors = 0;

  logic [W:0] exp_q[$];
  int         cyc = 0;
  logic       prev_done = 1'b0;
  int         done_cnt = 0;
  int         last_done_cyc = 0;
  int         last_gap = 0;

  serial_adder #(.W(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .cout    (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Scoreboard consumer: every done pulse must match the oldest launched op.
  always @(negedge clk) begin
    logic [W:0] e;
    if (done) begin
      check("done_consec", 32'(prev_done), 0);
      check("sb_nonempty", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("result", 32'({cout, sum_out}), 32'(e));
      end
      done_cnt      <= done_cnt + 1;
      last_gap      <= cyc - last_done_cyc;
      last_done_cyc <= cyc;
    end
    prev_done <= done;
  end

  // Start is driven just after a rising edge; the next edge accepts it.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W:0] exp_val;
    exp_val = {1'b0, av} + {1'b0, bv};
    start = 1'b1;
    a = av;
    b = bv;
    exp_q.push_back(exp_val);
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      check("busy_on", 32'(busy), 1);
      check("done_off", 32'(done), 0);
    end
    @(negedge clk);
    check("busy_end", 32'(busy), 0);
    check("done_on", 32'(done), 1);
    @(negedge clk);
    check("done_fall", 32'(done), 0);
    check("hold", 32'({cout, sum_out}), 32'(exp_val));
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int dc0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_sum", 32'(sum_out), 0);
    check("rst_cout", 32'(cout), 0);
    @(posedge clk); #1;

    run_op(4'd5, 4'd3);
    repeat (3) @(negedge clk);
    check("hold_idle", 32'({cout, sum_out}), 8);
    @(posedge clk); #1;
    run_op(4'd15, 4'd1);
    run_op(4'd15, 4'd15);
    run_op(4'd0, 4'd0);

    // Start during SHIFT must be ignored.
    dc0 = done_cnt;
    start = 1'b1; a = 4'd9; b = 4'd6;
    exp_q.push_back(5'd15);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; a = 4'd1; b = 4'd1;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    repeat (6) @(posedge clk);
    #1;
    check("ignored_start_pulses", 32'(done_cnt - dc0), 1);
    check("ignored_start_sum", 32'({cout, sum_out}), 15);

    // Reset on the third SHIFT cycle discards the operation.
    dc0 = done_cnt;
    start = 1'b1; a = 4'd7; b = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_sum", 32'(sum_out), 0);
    check("midrst_cout", 32'(cout), 0);
    repeat (6) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - dc0), 0);
    @(posedge clk); #1;
    run_op(4'd2, 4'd3);

    // start held high: back-to-back operations accepted from DONE.
    dc0 = done_cnt;
    start = 1'b1; a = 4'd10; b = 4'd12;
    exp_q.push_back(5'd22);
    @(posedge clk); #1;
    a = 4'd3; b = 4'd4;
    exp_q.push_back(5'd7);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b0;
    a = '0; b = '0;
    repeat (8) @(posedge clk);
    #1;
    check("b2b_pulses", 32'(done_cnt - dc0), 2);
    check("b2b_gap", 32'(last_gap), 5);
    check("b2b_final", 32'({cout, sum_out}), 7);

    check("sb_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
